output_layer_seq: RTL and testbench
===================================

OUTPUT_LAYER_SEQ -- requirements
Module: output_layer_seq

Interface
REQ-001 Parameter N_IN, default 30, inputs per output neuron.
REQ-002 Parameter N_OUT, default 10, output neurons (digit classes).
REQ-003 Parameter DW, default 8, signed weight/bias/activation width.
REQ-004 Parameter ACC_W, default 24, signed accumulator and score width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request one classification; accepted only in IDLE.
REQ-008 weights_OL  in  DW*N_OUT*N_IN  signed; weight(i,j) at bits [(i*N_IN+j)*DW +: DW].
REQ-009 biases_OL  in  DW*N_OUT  signed; bias(i) at bits [i*DW +: DW].
REQ-010 hid_act  in  DW*N_IN  signed hidden-layer activations; act(j) at bits [j*DW +: DW].
REQ-011 busy  out  1  high from the cycle after start acceptance through the DONE cycle.
REQ-012 done  out  1  one-cycle pulse; digit/score valid.
REQ-013 digit  out  4  index of winning neuron.
REQ-014 score  out  ACC_W  signed winning accumulator value.

Function
REQ-015 FSM states IDLE, BIAS, MAC, CMP, DONE; encoding free.
REQ-016 IDLE: start=1 latches hid_act into internal register, clears neuron counter, -> BIAS; start=0 stays.
REQ-017 BIAS: acc <= sign-extended bias(n); input counter j <= 0; -> MAC.
REQ-018 MAC: acc <= acc + sign-extended (weight(n,j) * act_latched(j)), 2*DW-bit signed product; j increments; after j = N_IN-1 -> CMP.
REQ-019 CMP: if n = 0 or acc > best (strict, signed), best <= acc and best_idx <= n; if n = N_OUT-1 -> DONE else n++ and -> BIAS.
REQ-020 Ties resolve to the lowest neuron index.
REQ-021 DONE: digit <= best_idx, score <= best, done = 1 for exactly this cycle; -> IDLE.
REQ-022 Latency: start sampled at edge 0 -> done high in cycle N_OUT*(N_IN+2)+1 (321 at defaults).
REQ-023 Throughput: at most one classification per N_OUT*(N_IN+2)+2 cycles; start in DONE state ignored.
REQ-024 start while busy is ignored and has no effect on the running job.
REQ-025 No saturation; ACC_W=24 covers N_IN*128*128 plus bias without overflow at defaults.
REQ-026 hid_act changes after acceptance do not affect the result; weights_OL/biases_OL held stable by system (constant ROM).
REQ-027 digit and score hold their values between done pulses.

Reset
REQ-028 rst=1 at any edge, including mid-job: state <= IDLE, busy=0, done=0, digit=0, score=0, acc, best, best_idx, counters and latched activations cleared.
REQ-029 A job interrupted by reset produces no done pulse; rst has priority over start.

Structure
REQ-030 N_IN, N_OUT, DW, ACC_W defaults and state encodings live in shared include nn_params.vh, used also by the hidden-layer sequencer.
REQ-031 Multiply-accumulate lives in one sub-module output_layer_mac (ports: clk, rst, clr_load, en, load value, a, b, acc); FSM, counters, operand muxing and argmax stay in output_layer_seq.

Verification
REQ-032 act all +1, weight(3,*)=+1, all other weights 0, biases 0, start -> done at cycle 321, digit=3, score=30.
REQ-033 act all 0, biases {i=7: +5, others -2} -> digit=7, score=5.
REQ-034 act all +127, all weights -128, biases 0 -> all tie, digit=0, score=-487680.
REQ-035 start, rst pulsed at cycle 100 -> busy=0 next cycle, no done pulse, digit=0; restart with REQ-032 stimulus -> correct result at 321 cycles after restart.
REQ-036 start held high continuously with REQ-032 stimulus -> done exactly once per 322 cycles, busy low only in IDLE cycles; hid_act changed to all 0 at cycle 5 -> result still digit=3, score=30.

Source files
------------

// File: rtl/output_layer_seq_pkg.sv
// Shared sizing defaults, FSM encoding and small helpers for the output layer.
package output_layer_seq_pkg;

   localparam int N_IN_D  = 30;
   localparam int N_OUT_D = 10;
   localparam int DW_D    = 8;
   localparam int ACC_W_D = 24;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_BIAS = 3'd1,
      ST_MAC  = 3'd2,
      ST_CMP  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/output_layer_seq_if.sv
// Job bus of the output-layer sequencer.
// Handshake: start is sampled on a rising edge and accepted only while the
// sequencer is idle (busy=0); starts seen while busy are dropped. done is a
// one-cycle pulse during which digit/score already carry the new result;
// digit/score then hold until the next done pulse.
interface output_layer_seq_if
   import output_layer_seq_pkg::*;
#(
   parameter int N_IN  = N_IN_D,
   parameter int N_OUT = N_OUT_D,
   parameter int DW    = DW_D,
   parameter int ACC_W = ACC_W_D
) ();

   logic                          start;
   logic [DW*N_OUT*N_IN-1:0]      weights_OL;
   logic [DW*N_OUT-1:0]           biases_OL;
   logic [DW*N_IN-1:0]            hid_act;
   logic                          busy;
   logic                          done;
   logic [3:0]                    digit;
   logic signed [ACC_W-1:0]       score;
   state_t                        state_dbg;

   modport master (
      output start, weights_OL, biases_OL, hid_act,
      input  busy, done, digit, score, state_dbg
   );

   modport slave (
      input  start, weights_OL, biases_OL, hid_act,
      output busy, done, digit, score, state_dbg
   );

endinterface

// File: rtl/output_layer_seq_mac.sv
// Accumulator for one neuron: load (bias) or add a signed DWxDW product.
module output_layer_mac #(
   parameter int DW    = 8,
   parameter int ACC_W = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr_load,
   input  logic                    en,
   input  logic signed [ACC_W-1:0] load_val,
   input  logic signed [DW-1:0]    a,
   input  logic signed [DW-1:0]    b,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [2*DW-1:0] prod;

   assign prod = a * b;

   // Load has priority over accumulate; the product is sign-extended.
   always_ff @(posedge clk) begin
      if (rst)           acc <= '0;
      else if (clr_load) acc <= load_val;
      else if (en)       acc <= acc + ACC_W'(prod);
   end

endmodule

// File: rtl/output_layer_seq.sv
// Sequential output layer: one MAC walks every neuron, argmax picks the digit.
module output_layer_seq
   import output_layer_seq_pkg::*;
#(
   parameter int N_IN  = N_IN_D,
   parameter int N_OUT = N_OUT_D,
   parameter int DW    = DW_D,
   parameter int ACC_W = ACC_W_D
) (
   input  logic                clk,
   input  logic                rst,
   output_layer_seq_if.slave   bus
);

   localparam int NW = cnt_w(N_OUT);
   localparam int JW = cnt_w(N_IN + 1);

   state_t                  state_q, state_d;
   logic [NW-1:0]           n_q;
   logic [JW-1:0]           j_q;
   logic signed [DW-1:0]    act_q [N_IN];
   logic signed [ACC_W-1:0] acc, best_q, score_q;
   logic [NW-1:0]           best_idx_q;
   logic [3:0]              digit_q;
   logic                    clr_load, mac_en, take, last_j, last_n;
   logic signed [DW-1:0]    w_sel, a_sel;
   logic signed [ACC_W-1:0] bias_ext;
   int                      w_idx, b_idx;

   output_layer_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
      .clk      (clk),
      .rst      (rst),
      .clr_load (clr_load),
      .en       (mac_en),
      .load_val (bias_ext),
      .a        (w_sel),
      .b        (a_sel),
      .acc      (acc)
   );

   // Operand selection for the current neuron/input and the argmax decision.
   always_comb begin
      w_idx    = (int'(n_q) * N_IN + int'(j_q)) * DW;
      b_idx    = int'(n_q) * DW;
      w_sel    = $signed(bus.weights_OL[w_idx +: DW]);
      bias_ext = ACC_W'($signed(bus.biases_OL[b_idx +: DW]));
      a_sel    = act_q[j_q];
      last_j   = (j_q == JW'(N_IN - 1));
      last_n   = (n_q == NW'(N_OUT - 1));
      take     = (n_q == '0) || (acc > best_q);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and MAC control strobes.
   always_comb begin
      state_d  = state_q;
      clr_load = 1'b0;
      mac_en   = 1'b0;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_BIAS;
         ST_BIAS: begin
            clr_load = 1'b1;
            state_d  = ST_MAC;
         end
         ST_MAC: begin
            mac_en = 1'b1;
            if (last_j) state_d = ST_CMP;
         end
         ST_CMP:  state_d = last_n ? ST_DONE : ST_BIAS;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Counters, latched activations, running best and the published result.
   // The result registers load on the last compare so they are valid in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_q        <= '0;
         j_q        <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         digit_q    <= '0;
         score_q    <= '0;
         for (int k = 0; k < N_IN; k++) act_q[k] <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (bus.start) begin
               n_q <= '0;
               for (int k = 0; k < N_IN; k++)
                  act_q[k] <= $signed(bus.hid_act[k*DW +: DW]);
            end
            ST_BIAS: j_q <= '0;
            ST_MAC:  j_q <= j_q + JW'(1);
            ST_CMP: begin
               if (take) begin
                  best_q     <= acc;
                  best_idx_q <= n_q;
               end
               if (last_n) begin
                  digit_q <= take ? 4'(n_q) : 4'(best_idx_q);
                  score_q <= take ? acc : best_q;
               end else begin
                  n_q <= n_q + NW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.digit     = digit_q;
   assign bus.score     = score_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_output_layer_seq.sv
// Directed bench for output_layer_seq: vector table plus reset/held-start runs.
module tb_output_layer_seq;
   import output_layer_seq_pkg::*;

   localparam int N_IN  = 30;
   localparam int N_OUT = 10;
   localparam int DW    = 8;
   localparam int LAT   = N_OUT * (N_IN + 2) + 1;

   typedef struct {
      logic signed [7:0] act_v;
      int                w_row;   // -1: every row gets w_val, else only this row
      logic signed [7:0] w_val;
      int                b_row;   // -1: every bias is b_lo, else this row is b_hi
      logic signed [7:0] b_hi;
      logic signed [7:0] b_lo;
      int                exp_digit;
      int                exp_score;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs [6];

   output_layer_seq_if bus_if ();

   output_layer_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic load_vec(input vec_t v);
      for (int i = 0; i < N_OUT; i++) begin
         for (int j = 0; j < N_IN; j++)
            bus_if.weights_OL[(i*N_IN+j)*DW +: DW] =
               (v.w_row == -1 || v.w_row == i) ? v.w_val : 8'sd0;
         bus_if.biases_OL[i*DW +: DW] = (v.b_row == i) ? v.b_hi : v.b_lo;
      end
      for (int j = 0; j < N_IN; j++) bus_if.hid_act[j*DW +: DW] = v.act_v;
   endtask

   // Called #1 after an edge while idle; returns #1 after the cycle following done.
   task automatic run_job(input string nm, input int ed, input int es);
      int cyc;
      bit seen;
      bus_if.start = 1'b1;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      check({nm, " busy_cycle1"}, bus_if.busy, 1);
      cyc  = 1;
      seen = 0;
      while (!seen && cyc < 1000) begin
         if (bus_if.done) seen = 1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      check({nm, " latency"}, cyc, LAT);
      check({nm, " digit"}, bus_if.digit, ed);
      check({nm, " score"}, bus_if.score, es);
      @(posedge clk); #1;
      check({nm, " done_width"}, bus_if.done, 0);
      check({nm, " busy_after"}, bus_if.busy, 0);
      check({nm, " digit_hold"}, bus_if.digit, ed);
      check({nm, " score_hold"}, bus_if.score, es);
   endtask

   initial begin
      int cyc, done_cnt, busy_bad, prev_done;

      vecs[0] = '{8'sd1,    3, 8'sd1,    -1, 8'sd0,    8'sd0,  3, 30};
      vecs[1] = '{8'sd0,   -1, 8'sd0,     7, 8'sd5,   -8'sd2,  7, 5};
      vecs[2] = '{8'sd127, -1, -8'sd128, -1, 8'sd0,    8'sd0,  0, -487680};
      vecs[3] = '{-8'sd1,   5, -8'sd1,   -1, 8'sd0,    8'sd0,  5, 30};
      vecs[4] = '{8'sd1,    6, 8'sd2,     6, -8'sd100, 8'sd0,  0, 0};
      vecs[5] = '{8'sd3,   -1, 8'sd1,     8, 8'sd1,    8'sd0,  8, 91};

      bus_if.start      = 1'b0;
      bus_if.weights_OL = '0;
      bus_if.biases_OL  = '0;
      bus_if.hid_act    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", bus_if.busy, 0);
      check("reset done", bus_if.done, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("reset digit", bus_if.digit, 0);
      check("reset score", bus_if.score, 0);
      check("reset state", bus_if.state_dbg, ST_IDLE);

      // Table-driven jobs.
      for (int v = 0; v < 6; v++) begin
         load_vec(vecs[v]);
         run_job($sformatf("vec%0d", v), vecs[v].exp_digit, vecs[v].exp_score);
      end

      // Reset in the middle of a job, then restart.
      load_vec(vecs[0]);
      bus_if.start = 1'b1;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst busy", bus_if.busy, 0);
      check("midrst done", bus_if.done, 0);
      check("midrst digit", bus_if.digit, 0);
      check("midrst score", bus_if.score, 0);
      done_cnt = 0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         if (bus_if.done) done_cnt++;
      end
      check("midrst no_done", done_cnt, 0);
      run_job("restart", 3, 30);

      // start held high; activations cleared at cycle 5 of the first job.
      load_vec(vecs[0]);
      bus_if.start = 1'b1;
      @(posedge clk); #1;
      cyc       = 1;
      done_cnt  = 0;
      busy_bad  = 0;
      prev_done = 0;
      while (done_cnt < 2 && cyc < 1500) begin
         if (cyc == 5) bus_if.hid_act = '0;
         if (bus_if.busy !== ((prev_done != 0) ? 1'b0 : 1'b1)) busy_bad++;
         if (bus_if.done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               check("held done1 cycle", cyc, LAT);
               check("held done1 digit", bus_if.digit, 3);
               check("held done1 score", bus_if.score, 30);
            end else begin
               check("held done2 cycle", cyc, 2*LAT + 1);
               check("held done2 digit", bus_if.digit, 0);
               check("held done2 score", bus_if.score, 0);
            end
         end
         prev_done = bus_if.done ? 1 : 0;
         if (done_cnt < 2) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      bus_if.start = 1'b0;
      check("held done count", done_cnt, 2);
      check("held busy pattern errors", busy_bad, 0);
      @(posedge clk); #1;
      check("held idle busy", bus_if.busy, 0);
      repeat (3) @(posedge clk);
      #1;
      check("held idle done", bus_if.done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
